projection_bbox_detector: RTL

//  Next-generation projection bounding-box finder for the binary-image pipeline. Accumulates per-column and
//  per-row foreground pixel COUNTS over one frame and compares each against a runtime threshold, instead of a
//  1-bit "any pixel" mark. Reports the first/last qualifying column and row as a bbox once per frame.

---
 rtl/projection_bbox_detector.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/projection_bbox_detector.sv
// Projection bbox finder: counts foreground pixels per column (RAM) and per row (running),
// thresholds them and reports a margined bounding box once per frame.
module projection_bbox_detector #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int DATA_W  = 24,
  parameter int COORD_W = 12,
  parameter int CNT_W   = 10
) (
  input  logic               pixelclk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  i_binary,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [COORD_W-1:0] i_hcount,
  input  logic [COORD_W-1:0] i_vcount,
  input  logic               i_fg_zero,
  input  logic [CNT_W-1:0]   i_col_thresh,
  input  logic [CNT_W-1:0]   i_row_thresh,
  input  logic [7:0]         i_h_margin,
  input  logic [7:0]         i_v_margin,
  output logic [COORD_W-1:0] o_hcount_l,
  output logic [COORD_W-1:0] o_hcount_r,
  output logic [COORD_W-1:0] o_vcount_l,
  output logic [COORD_W-1:0] o_vcount_r,
  output logic               o_found,
  output logic               o_bbox_valid,
  output logic               o_overrun,
  output logic               o_busy
);
  localparam int AW = $clog2(IMG_W);
  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
  localparam logic [COORD_W-1:0] W_LAST    = COORD_W'(IMG_W - 1);
  localparam logic [COORD_W-1:0] H_LAST    = COORD_W'(IMG_H - 1);
  localparam logic [COORD_W:0]   W_SIZE    = (COORD_W+1)'(IMG_W);
  localparam logic [COORD_W:0]   H_SIZE    = (COORD_W+1)'(IMG_H);
  localparam logic [COORD_W:0]   CLR_LAST  = (COORD_W+1)'(IMG_W - 1);
  localparam logic [COORD_W:0]   SCAN_LAST = (COORD_W+1)'(IMG_W + 1);
  localparam logic [COORD_W:0]   ONE       = (COORD_W+1)'(1);

  typedef enum logic [1:0] {CLEAR, WAIT_SOF, ACCUM, SCAN} state_t;
  state_t state, state_n;

  logic               vs_d1, de_d1;
  logic [COORD_W:0]   cnt;
  logic               fe, pix_ok, fg_now;

  logic               cur_fgz;
  logic [CNT_W-1:0]   cur_col_th, cur_row_th, scan_col_th;
  logic [7:0]         cur_hm, cur_vm, scan_hm, scan_vm;

  logic [CNT_W-1:0]   row_cnt;
  logic [COORD_W-1:0] row_last, row_top, row_bot, scan_top, scan_bot;
  logic               row_found, scan_row_found;

  logic               col_found;
  logic [COORD_W-1:0] left, right;
  logic               dirty, scan_dirty;

  logic [CNT_W-1:0]   col_mem [IMG_W];
  logic [CNT_W-1:0]   ram_rd, ram_wd;
  logic [AW-1:0]      ram_ra, ram_wa, p_addr;
  logic               ram_we, p_valid;

  assign fe     = vs_d1 & ~i_vs;
  assign pix_ok = i_de && ({1'b0, i_hcount} < W_SIZE) && ({1'b0, i_vcount} < H_SIZE);
  assign fg_now = cur_fgz ? (i_binary == '0) : (i_binary != '0);
  assign o_busy = !reset && (state == CLEAR || state == SCAN);

  // Margin one axis; if the margined edges cross, collapse to the unmargined midpoint.
  function automatic logic [2*COORD_W-1:0] apply_margin(input logic [COORD_W-1:0] lo,
                                                        input logic [COORD_W-1:0] hi,
                                                        input logic [7:0] m,
                                                        input logic [COORD_W-1:0] last);
    logic [COORD_W:0]   sum;
    logic [COORD_W-1:0] a, b, mid;
    sum = {1'b0, lo} + (COORD_W+1)'(m);
    a   = (sum > {1'b0, last}) ? last : COORD_W'(sum);
    b   = (hi > COORD_W'(m)) ? hi - COORD_W'(m) : '0;
    mid = COORD_W'(({1'b0, lo} + {1'b0, hi}) >> 1);
    if (a > b) begin
      a = mid;
      b = mid;
    end
    return {a, b};
  endfunction

  always_ff @(posedge pixelclk) begin
    if (reset) state <= CLEAR;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      CLEAR:    if (cnt == CLR_LAST) state_n = WAIT_SOF;
      WAIT_SOF: if (fe) state_n = ACCUM;
      ACCUM:    if (fe) state_n = SCAN;
      SCAN:     if (cnt == SCAN_LAST) state_n = ACCUM;
      default:  state_n = CLEAR;
    endcase
  end

  // Column RAM port: pending read-modify-write wins; otherwise clear or scan-behind zeroing.
  always_comb begin
    ram_ra = (state == SCAN) ? AW'(cnt) : i_hcount[AW-1:0];
    ram_we = 1'b0;
    ram_wa = '0;
    ram_wd = '0;
    if (p_valid) begin
      ram_we = 1'b1;
      ram_wa = p_addr;
      ram_wd = (ram_rd == CNT_MAX) ? CNT_MAX : ram_rd + CNT_ONE;
    end else if (state == CLEAR) begin
      ram_we = 1'b1;
      ram_wa = AW'(cnt);
    end else if (state == SCAN && cnt >= ONE && cnt <= W_SIZE) begin
      ram_we = 1'b1;
      ram_wa = AW'(cnt - ONE);
    end
  end

  always_ff @(posedge pixelclk) begin
    if (ram_we) col_mem[ram_wa] <= ram_wd;
    ram_rd <= col_mem[ram_ra];
  end

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      vs_d1 <= 1'b0;  de_d1 <= 1'b0;  cnt <= '0;
      cur_fgz <= 1'b0;  cur_col_th <= '0;  cur_row_th <= '0;  scan_col_th <= '0;
      cur_hm <= '0;  cur_vm <= '0;  scan_hm <= '0;  scan_vm <= '0;
      row_cnt <= '0;  row_last <= '0;  row_top <= '0;  row_bot <= '0;  row_found <= 1'b0;
      scan_top <= '0;  scan_bot <= '0;  scan_row_found <= 1'b0;
      col_found <= 1'b0;  left <= '0;  right <= '0;
      dirty <= 1'b0;  scan_dirty <= 1'b0;  p_valid <= 1'b0;  p_addr <= '0;
      o_hcount_l <= '0;  o_hcount_r <= '0;  o_vcount_l <= '0;  o_vcount_r <= '0;
      o_found <= 1'b0;  o_bbox_valid <= 1'b0;  o_overrun <= 1'b0;
    end else begin
      vs_d1        <= i_vs;
      de_d1        <= i_de;
      o_bbox_valid <= 1'b0;
      p_valid      <= pix_ok && fg_now && (state == ACCUM);
      p_addr       <= i_hcount[AW-1:0];

      if (state_n != state)                  cnt <= '0;
      else if (state == CLEAR || state == SCAN) cnt <= cnt + ONE;

      if (fe) begin
        cur_fgz    <= i_fg_zero;
        cur_col_th <= (i_col_thresh == '0) ? CNT_ONE : i_col_thresh;
        cur_row_th <= (i_row_thresh == '0) ? CNT_ONE : i_row_thresh;
        cur_hm     <= i_h_margin;
        cur_vm     <= i_v_margin;
        row_cnt    <= '0;
        row_found  <= 1'b0;
        row_top    <= '0;
        row_bot    <= '0;
        if (state == ACCUM) begin
          scan_col_th    <= cur_col_th;
          scan_hm        <= cur_hm;
          scan_vm        <= cur_vm;
          scan_top       <= row_top;
          scan_bot       <= row_bot;
          scan_row_found <= row_found;
          scan_dirty     <= dirty;
          col_found      <= 1'b0;
          left           <= '0;
          right          <= '0;
        end
        // An FE while still scanning means the next frame is already compromised.
        dirty <= (state == SCAN);
      end else if (pix_ok) begin
        row_cnt  <= (row_cnt == CNT_MAX) ? CNT_MAX : row_cnt + CNT_W'(fg_now);
        row_last <= i_vcount;
      end else if (de_d1 && !i_de) begin
        if (row_cnt >= cur_row_th) begin
          if (!row_found) row_top <= row_last;
          row_bot   <= row_last;
          row_found <= 1'b1;
        end
        row_cnt <= '0;
      end

      if (pix_ok && state == SCAN) dirty <= 1'b1;
      if (pix_ok && (state == CLEAR || state == SCAN)) o_overrun <= 1'b1;

      if (state == SCAN && cnt >= ONE && cnt <= W_SIZE && ram_rd >= scan_col_th) begin
        if (!col_found) left <= COORD_W'(cnt - ONE);
        right     <= COORD_W'(cnt - ONE);
        col_found <= 1'b1;
      end

      if (state == SCAN && cnt == SCAN_LAST && !scan_dirty) begin
        o_bbox_valid <= 1'b1;
        if (col_found && scan_row_found) begin
          o_found                  <= 1'b1;
          {o_hcount_l, o_hcount_r} <= apply_margin(left, right, scan_hm, W_LAST);
          {o_vcount_l, o_vcount_r} <= apply_margin(scan_top, scan_bot, scan_vm, H_LAST);
        end else begin
          o_found    <= 1'b0;
          o_hcount_l <= '0;
          o_hcount_r <= '0;
          o_vcount_l <= '0;
          o_vcount_r <= '0;
        end
      end
    end
  end
endmodule
